// File: rtl/stream_reduce_pkg.sv
// Shared stream definitions for stream_reduce: flag bit positions and FSM states.
// Used by stream_reduce and stream_reduce_acc.
package stream_reduce_pkg;

  // Master flag vector layout: {again, first, last, vld}
  localparam int MF_AGAIN = 3;
  localparam int MF_FIRST = 2;
  localparam int MF_LAST  = 1;
  localparam int MF_VLD   = 0;

  // Slave flag vector layout: {abt, bsy}
  localparam int SF_ABT = 1;
  localparam int SF_BSY = 0;

  // Reducer states: waiting for a packet start, or summing a group
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/stream_reduce_acc.sv
// Group accumulator for stream_reduce: running sum, beat counter, group size and
// close detection. o_sum / o_close describe the beat presented this cycle, so the
// top can load the output register in the same cycle the closing beat is accepted.
// With STREAM_REDUCE_SAT_EN defined the sum saturates at all-ones of WO bits.
module stream_reduce_acc
  import stream_reduce_pkg::*;
#(
  parameter int W    = 32,
  parameter int NMAX = 16,
  parameter int CW   = 5,
  parameter int WO   = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_start,
  input  logic          i_cont,
  input  logic          i_last,
  input  logic [W-1:0]  i_d,
  input  logic [CW-1:0] i_n,
  output logic [WO-1:0] o_sum,
  output logic          o_close
);

  logic [WO-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_ng;

  logic          w_step;
  logic [CW-1:0] w_n_eff;
  logic [WO-1:0] w_base;
  logic [CW-1:0] w_base_cnt;
  logic [CW-1:0] w_ng;
  logic [CW-1:0] w_cnt;
  logic [WO:0]   w_wide;

  // Next sum/count for the presented beat; a start beat begins from an empty group
  always_comb begin
    w_n_eff = i_n;
    if (i_n == '0) begin
      w_n_eff = CW'(1);
    end else if (i_n > CW'(NMAX)) begin
      // Groups larger than NMAX could overflow the widened sum, so clamp them
      w_n_eff = CW'(NMAX);
    end
    w_step     = i_start | i_cont;
    w_base     = i_start ? '0 : r_acc;
    w_base_cnt = i_start ? '0 : r_cnt;
    w_ng       = i_start ? w_n_eff : r_ng;
    w_wide     = {1'b0, w_base} + {{(WO + 1 - W){1'b0}}, i_d};
`ifdef STREAM_REDUCE_SAT_EN
    // Carry out means the true sum no longer fits; pin it at the maximum
    o_sum      = w_wide[WO] ? {WO{1'b1}} : w_wide[WO-1:0];
`else
    o_sum      = w_wide[WO-1:0];
`endif
    w_cnt      = w_base_cnt + CW'(1);
    o_close    = w_step & ((w_cnt == w_ng) | i_last);
  end

  // Group state: cleared on abort or close, otherwise updated per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ng  <= CW'(1);
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_step) begin
      if (i_start) begin
        r_ng <= w_n_eff;
      end
      if (o_close) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= o_sum;
        r_cnt <= w_cnt;
      end
    end
  end

endmodule

// File: rtl/stream_reduce.sv
// stream_reduce: collapses each run of N beats of a packet into one beat carrying
// their sum, moving first/last framing to the first/last output beat.
// Handshake: a beat moves across an interface in a cycle where its vld=1 and the
// receiver's bsy=0; the upstream bsy is cd_vld & dc_bsy (the only combinational
// path), abt is passed straight upstream and flushes all state one cycle later.
// Optional feature macro: STREAM_REDUCE_SAT_EN (saturating W-bit sum instead of
// the widened W+$clog2(NMAX)-bit sum).
module stream_reduce
  import stream_reduce_pkg::*;
#(
  parameter  int W    = 32,
  parameter  int NMAX = 16,
  localparam int CW   = $clog2(NMAX + 1),
`ifdef STREAM_REDUCE_SAT_EN
  localparam int WO   = W
`else
  localparam int WO   = W + $clog2(NMAX)
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] N,
  input  logic [W-1:0]  uc_d0,
  input  logic [3:0]    uc_mflags,
  output logic [1:0]    cu_sflags,
  output logic [WO-1:0] cd_d0,
  output logic [3:0]    cd_mflags,
  input  logic [1:0]    dc_sflags,
  output state_t        o_dbg_state
);

  state_t        r_state;
  logic          r_grp_first;
  logic [WO-1:0] r_d0;
  logic          r_vld;
  logic          r_first;
  logic          r_last;
  logic          r_again;

  logic          w_uc_vld;
  logic          w_uc_first;
  logic          w_uc_last;
  logic          w_unused_again;
  logic          w_dc_bsy;
  logic          w_dc_abt;
  logic          w_cu_bsy;
  logic          w_take;
  logic          w_start;
  logic          w_cont;
  logic          w_drain;
  logic [WO-1:0] w_sum;
  logic          w_close;

  // Flag unpacking and handshake decode
  always_comb begin
    w_uc_vld       = uc_mflags[MF_VLD];
    w_uc_first     = uc_mflags[MF_FIRST];
    w_uc_last      = uc_mflags[MF_LAST];
    w_unused_again = uc_mflags[MF_AGAIN];
    w_dc_bsy       = dc_sflags[SF_BSY];
    w_dc_abt       = dc_sflags[SF_ABT];
    w_cu_bsy       = r_vld & w_dc_bsy;
    // Beats accepted during an abort are discarded, so they never reach the group
    w_take         = w_uc_vld & ~w_cu_bsy & ~w_dc_abt;
    // A first beat always (re)starts a packet, abandoning any partial group
    w_start        = w_take & w_uc_first;
    w_cont         = w_take & ~w_uc_first & (r_state == ST_ACC);
    w_drain        = r_vld & ~w_dc_bsy;
  end

  stream_reduce_acc #(
    .W    (W),
    .NMAX (NMAX),
    .CW   (CW),
    .WO   (WO)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_dc_abt),
    .i_start (w_start),
    .i_cont  (w_cont),
    .i_last  (w_uc_last),
    .i_d     (uc_d0),
    .i_n     (N),
    .o_sum   (w_sum),
    .o_close (w_close)
  );

  // Packet FSM and single-entry output register (load and drain may coincide)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grp_first <= 1'b0;
      r_d0        <= '0;
      r_vld       <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_again     <= 1'b0;
    end else if (w_dc_abt) begin
      r_state     <= ST_IDLE;
      r_grp_first <= 1'b0;
      r_vld       <= 1'b0;
      r_again     <= 1'b0;
    end else begin
      r_again <= r_vld & w_dc_bsy;
      if (w_close) begin
        r_d0        <= w_sum;
        r_vld       <= 1'b1;
        r_first     <= w_start | r_grp_first;
        r_last      <= w_uc_last;
        r_grp_first <= 1'b0;
        r_state     <= w_uc_last ? ST_IDLE : ST_ACC;
      end else begin
        if (w_drain) begin
          r_vld <= 1'b0;
        end
        if (w_start) begin
          r_grp_first <= 1'b1;
          r_state     <= ST_ACC;
        end
      end
    end
  end

  // Flag packing toward both neighbours
  always_comb begin
    cu_sflags           = '0;
    cu_sflags[SF_ABT]   = w_dc_abt;
    cu_sflags[SF_BSY]   = w_cu_bsy;
    cd_mflags           = '0;
    cd_mflags[MF_AGAIN] = r_again;
    cd_mflags[MF_FIRST] = r_first;
    cd_mflags[MF_LAST]  = r_last;
    cd_mflags[MF_VLD]   = r_vld;
    cd_d0               = r_d0;
    o_dbg_state         = r_state;
  end

endmodule

// File: tb/tb_stream_reduce.sv
// Testbench for stream_reduce: directed scenarios plus randomized packets, with a
// queue-based scoreboard fed by a packet-level reference model and drained by an
// independent output monitor.
module tb_stream_reduce;
  import stream_reduce_pkg::*;

  localparam int W    = 8;
  localparam int NMAX = 4;
  localparam int CW   = $clog2(NMAX + 1);
`ifdef STREAM_REDUCE_SAT_EN
  localparam int WO   = W;
  localparam logic [63:0] SAT_EXP = 64'd255;
`else
  localparam int WO   = W + $clog2(NMAX);
  localparam logic [63:0] SAT_EXP = 64'd311;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] n_in;
  logic [W-1:0]  uc_d0;
  logic [3:0]    uc_mflags;
  logic [1:0]    cu_sflags;
  logic [WO-1:0] cd_d0;
  logic [3:0]    cd_mflags;
  logic [1:0]    dc_sflags;
  state_t        dbg_state;

  always #5 clk = ~clk;

  stream_reduce #(.W(W), .NMAX(NMAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .N           (n_in),
    .uc_d0       (uc_d0),
    .uc_mflags   (uc_mflags),
    .cu_sflags   (cu_sflags),
    .cd_d0       (cd_d0),
    .cd_mflags   (cd_mflags),
    .dc_sflags   (dc_sflags),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [WO+1:0] exp_q[$];   // {data, first, last}
  logic [WO-1:0] seen_q[$];  // data of every beat the monitor saw leave
  int n_cmp = 0;
  int n_err = 0;
  logic lat_due = 1'b0;
  logic [1:0]    s_cu;
  logic [3:0]    s_md;
  logic [WO-1:0] s_d0;
  state_t        s_state;

  // Reference model: packet/group view of the stream
  bit m_in_pkt = 0;
  int m_ng = 1;
  int m_grp[$];
  bit m_gfirst = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_beat(input logic [W-1:0] d, input logic first, input logic last,
                            output logic pushed);
    logic [63:0] s;
    pushed = 1'b0;
    if (first) begin
      m_in_pkt = 1;
      m_ng     = (n_in == 0) ? 1 : int'(n_in);
      m_grp.delete();
      m_gfirst = 1;
    end else if (!m_in_pkt) begin
      return;
    end
    m_grp.push_back(int'(d));
    if (m_grp.size() == m_ng || last) begin
      s = 0;
      foreach (m_grp[i]) s += 64'(m_grp[i]);
`ifdef STREAM_REDUCE_SAT_EN
      if (s > ((64'd1 << W) - 1)) s = (64'd1 << W) - 1;
`endif
      exp_q.push_back({s[WO-1:0], m_gfirst, last});
      pushed = 1'b1;
      m_grp.delete();
      m_gfirst = 0;
      if (last) m_in_pkt = 0;
    end
  endtask

  task automatic model_abort();
    m_in_pkt = 0;
    m_grp.delete();
  endtask

  // ---------------- driver tasks ----------------
  // One cycle of stimulus; inputs change just after posedge, sampling at negedge
  task automatic drive_cycle(input logic vld, input logic [W-1:0] d, input logic first,
                             input logic last, input logic bsy, input logic abt,
                             output logic acc);
    logic pushed;
    uc_d0     = d;
    uc_mflags = {1'($urandom_range(0, 1)), first, last, vld};
    dc_sflags = {abt, bsy};
    @(negedge clk);
    s_cu    = cu_sflags;
    s_md    = cd_mflags;
    s_d0    = cd_d0;
    s_state = dbg_state;
    if (lat_due) check("latency_vld", 64'(cd_mflags[MF_VLD]), 64'd1);
    acc    = vld && !cu_sflags[SF_BSY];
    pushed = 1'b0;
    if (abt) model_abort();
    else if (acc) model_beat(d, first, last, pushed);
    lat_due = pushed;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic first, input logic last);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      drive_cycle(1'b1, d, first, last, 1'($urandom_range(0, 3) == 0), 1'b0, acc);
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int cycles);
    logic a;
    for (int t = 0; t < cycles; t++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, a);
  endtask

  task automatic drain();
    logic a;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++)
      drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [WO+1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && cd_mflags[MF_VLD] && !dc_sflags[SF_BSY]) begin
        seen_q.push_back(cd_d0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got data %0h with no beat expected at %0t", cd_d0, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(cd_d0), 64'(e[WO+1:2]));
          check("out_first", 64'(cd_mflags[MF_FIRST]), 64'(e[1]));
          check("out_last", 64'(cd_mflags[MF_LAST]), 64'(e[0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic a;
    int len;
    n_in      = CW'(1);
    uc_d0     = '0;
    uc_mflags = '0;
    dc_sflags = 2'b10;

    // Reset state; abort is mirrored even in reset
    #12;
    check("rst_cu_sflags_abt", 64'(cu_sflags), 64'd2);
    check("rst_cd_mflags", 64'(cd_mflags), 64'd0);
    check("rst_cd_d0", 64'(cd_d0), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    dc_sflags = 2'b00;
    #1;
    check("rst_cu_sflags", 64'(cu_sflags), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // N=4, beats 1..8 -> 10, 26
    n_in = CW'(4);
    seen_q.delete();
    for (int i = 1; i <= 8; i++) drive_cycle(1'b1, W'(i), 1'(i == 1), 1'(i == 8), 1'b0, 1'b0, a);
    drain();
    check("t1_count", 64'(seen_q.size()), 64'd2);
    check("t1_sum0", 64'(seen_q[0]), 64'd10);
    check("t1_sum1", 64'(seen_q[1]), 64'd26);

    // N=3, five beats of 7 -> 21, 14 (short final flush)
    n_in = CW'(3);
    seen_q.delete();
    for (int i = 0; i < 5; i++) send_beat(W'(7), 1'(i == 0), 1'(i == 4));
    drain();
    check("t2_count", 64'(seen_q.size()), 64'd2);
    check("t2_sum1", 64'(seen_q[1]), 64'd14);

    // N=1, single beat first=last=1
    n_in = CW'(1);
    seen_q.delete();
    drive_cycle(1'b1, W'(8'h55), 1'b1, 1'b1, 1'b0, 1'b0, a);
    drain();
    check("t3_data", 64'(seen_q[0]), 64'h55);

    // N=2, downstream busy for 3 cycles while a sum is held
    n_in = CW'(2);
    drive_cycle(1'b1, W'(5), 1'b1, 1'b0, 1'b0, 1'b0, a);
    drive_cycle(1'b1, W'(6), 1'b0, 1'b0, 1'b0, 1'b0, a);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, W'(7), 1'b0, 1'b0, 1'b1, 1'b0, a);
      check("hold_cu_bsy", 64'(s_cu[SF_BSY]), 64'd1);
      check("hold_again", 64'(s_md[MF_AGAIN]), 64'(k > 0));
      check("hold_d0", 64'(s_d0), 64'd11);
      check("hold_no_accept", 64'(a), 64'd0);
    end
    send_beat(W'(7), 1'b0, 1'b0);
    send_beat(W'(8), 1'b0, 1'b1);
    drain();
    idle(1);
    check("post_hold_again", 64'(cd_mflags[MF_AGAIN]), 64'd0);

    // Abort after 2 of 4 beats; stray non-first beat afterwards must be dropped
    n_in = CW'(4);
    drive_cycle(1'b1, W'(1), 1'b1, 1'b0, 1'b0, 1'b0, a);
    drive_cycle(1'b1, W'(1), 1'b0, 1'b0, 1'b0, 1'b0, a);
    drive_cycle(1'b1, W'(1), 1'b0, 1'b0, 1'b0, 1'b1, a);
    check("abt_mirror", 64'(s_cu[SF_ABT]), 64'd1);
    drive_cycle(1'b1, W'(1), 1'b0, 1'b0, 1'b0, 1'b0, a);
    check("abt_state", 64'(s_state), 64'(ST_IDLE));
    check("abt_vld", 64'(s_md[MF_VLD]), 64'd0);
    check("abt_again", 64'(s_md[MF_AGAIN]), 64'd0);
    check("abt_release", 64'(s_cu[SF_ABT]), 64'd0);
    seen_q.delete();
    for (int i = 0; i < 4; i++) send_beat(W'(1), 1'(i == 0), 1'(i == 3));
    drain();
    check("abt_next_sum", 64'(seen_q[0]), 64'd4);

    // Wide values: 200,100,10,1 -> saturated 255 or widened 311
    seen_q.delete();
    send_beat(W'(200), 1'b1, 1'b0);
    send_beat(W'(100), 1'b0, 1'b0);
    send_beat(W'(10), 1'b0, 1'b0);
    send_beat(W'(1), 1'b0, 1'b1);
    drain();
    check("sat_sum", 64'(seen_q[0]), SAT_EXP);

    // Reset in mid-packet drops the partial group
    send_beat(W'(3), 1'b1, 1'b0);
    send_beat(W'(4), 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_mflags", 64'(cd_mflags), 64'd0);
    check("midrst_d0", 64'(cd_d0), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    model_abort();
    lat_due = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(W'(9), 1'b0, 1'b1);
    n_in = CW'(2);
    seen_q.delete();
    send_beat(W'(1), 1'b1, 1'b0);
    send_beat(W'(2), 1'b0, 1'b1);
    drain();
    check("midrst_next", 64'(seen_q.size()), 64'd1);

    // Randomized packets: group sizes 0..NMAX, restarts, strays, aborts, backpressure
    for (int p = 0; p < 80; p++) begin
      n_in = CW'($urandom_range(0, NMAX));
      len  = $urandom_range(1, 10);
      if ($urandom_range(0, 7) == 0) send_beat(W'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      for (int b = 0; b < len; b++) begin
        if (b > 0 && b < len - 1 && $urandom_range(0, 14) == 0) break;
        if (b > 0 && $urandom_range(0, 24) == 0)
          drive_cycle(1'($urandom_range(0, 1)), W'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, a);
        send_beat(W'($urandom), 1'(b == 0), 1'(b == len - 1));
        if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
